// File: rtl/pc_control_pkg.sv
// pc_control_pkg
//   Shared types for the program-counter controller: control-flow opcode
//   encodings seen from execute, controller state encodings, and a small
//   helper that recognises unconditional jumps.
package pc_control_pkg;

    // Control-flow opcode presented by the execute stage.
    typedef enum logic [1:0] {
        PC_OP_NONE   = 2'd0,
        PC_OP_BRANCH = 2'd1,
        PC_OP_JAL    = 2'd2,
        PC_OP_JALR   = 2'd3
    } pc_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_TRAP  = 2'd3
    } pc_state_e;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // JAL and JALR always redirect and always write a link value.
    function automatic logic is_jump(input pc_op_e op);
        return (op == PC_OP_JAL) || (op == PC_OP_JALR);
    endfunction

endpackage

// File: rtl/pc_control_if.sv
// pc_control_if
//   Bundles the fetch-side handshake and the execute-side control-flow bus
//   of the program-counter controller.
//   Fetch side : stall, fetch_ready -> controller; fetch_valid, pc, flush <- controller
//   Execute    : ex_valid, ex_op, jump_condition, ex_pc, ex_imm, ex_rs1 -> controller
//   Results    : taken, target, link_value, misaligned <- controller
//   modport master : the controller itself
//   modport slave  : the surrounding pipeline / fetch unit
interface pc_control_if;
    import pc_control_pkg::*;

    logic        stall;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic        flush;
    logic        ex_valid;
    pc_op_e      ex_op;
    logic        jump_condition;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic        taken;
    logic [31:0] target;
    logic [31:0] link_value;
    logic        misaligned;

    modport master (
        input  stall, fetch_ready, ex_valid, ex_op, jump_condition,
               ex_pc, ex_imm, ex_rs1,
        output fetch_valid, pc, flush, taken, target, link_value, misaligned
    );

    modport slave (
        output stall, fetch_ready, ex_valid, ex_op, jump_condition,
               ex_pc, ex_imm, ex_rs1,
        input  fetch_valid, pc, flush, taken, target, link_value, misaligned
    );

endinterface

// File: rtl/pc_control_branch_target.sv
// pc_control_branch_target
//   Purely combinational redirect-target adder and alignment check.
//   ex_op_i, ex_pc_i, ex_imm_i, ex_rs1_i -> target_o, target_misaligned_o
//   BRANCH/JAL use ex_pc + imm; JALR uses (rs1 + imm) with bit 0 cleared.
module pc_control_branch_target
    import pc_control_pkg::*;
(
    input  pc_op_e      ex_op_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_imm_i,
    input  logic [31:0] ex_rs1_i,
    output logic [31:0] target_o,
    output logic        target_misaligned_o
);

    // Select the base by opcode; the adds wrap naturally at 32 bits.
    always_comb begin
        target_o = ex_pc_i + ex_imm_i;
        if (ex_op_i == PC_OP_JALR) begin
            target_o = (ex_rs1_i + ex_imm_i) & ~32'h1;
        end
    end

    // Only bit 1 matters: bit 0 is either cleared (JALR) or zero by encoding.
    assign target_misaligned_o = target_o[1];

endmodule

// File: rtl/pc_control.sv
// pc_control
//   Owns the program counter, issues fetch requests, resolves BRANCH/JAL/JALR
//   redirects from execute, flushes wrong-path work for FLUSH_CYCLES cycles
//   and traps (until reset) on a redirect whose target has bit 1 set.
//   clk, reset : clock and synchronous active-high reset
//   bus        : pc_control_if.master (fetch handshake, execute bus, results)
module pc_control
    import pc_control_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
)
(
    input  logic           clk,
    input  logic           reset,
    pc_control_if.master   bus
);

    // The counter holds the bubbles remaining after the current one.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    pc_state_e   state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;
    logic [31:0] link_q, link_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] redirect_target;
    logic        redirect_misaligned;
    logic        redirect;

    pc_control_branch_target u_branch_target (
        .ex_op_i             (bus.ex_op),
        .ex_pc_i             (bus.ex_pc),
        .ex_imm_i            (bus.ex_imm),
        .ex_rs1_i            (bus.ex_rs1),
        .target_o            (redirect_target),
        .target_misaligned_o (redirect_misaligned)
    );

    assign redirect = bus.ex_valid &&
                      (is_jump(bus.ex_op) ||
                       ((bus.ex_op == PC_OP_BRANCH) && bus.jump_condition));

    // State, counter, PC and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            flush_cnt_q  <= '0;
            pc_q         <= RESET_VECTOR;
            taken_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            pc_q         <= pc_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            link_q       <= link_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state logic. taken is a one-cycle pulse, so it defaults low;
    // everything else holds unless the current state says otherwise.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pc_d         = pc_q;
        taken_d      = 1'b0;
        target_d     = target_q;
        link_d       = link_q;
        misaligned_d = misaligned_q;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // The link value is written even when the jump then traps.
                if (bus.ex_valid && is_jump(bus.ex_op)) begin
                    link_d = bus.ex_pc + INSTR_BYTES;
                end
                if (redirect) begin
                    if (redirect_misaligned) begin
                        state_d      = ST_TRAP;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d     = ST_FLUSH;
                        pc_d        = redirect_target;
                        taken_d     = 1'b1;
                        target_d    = redirect_target;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end else if (bus.fetch_ready && !bus.stall) begin
                    pc_d = pc_q + INSTR_BYTES;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    assign bus.fetch_valid = (state_q == ST_RUN);
    assign bus.flush       = (state_q == ST_FLUSH);
    assign bus.pc          = pc_q;
    assign bus.taken       = taken_q;
    assign bus.target      = target_q;
    assign bus.link_value  = link_q;
    assign bus.misaligned  = misaligned_q;

endmodule
